// File: rtl/iso16_pkg.sv
// rtl/iso16_pkg.sv - shared ISO-16 plugin bank types, widths and lane helpers
package iso16_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_COLLECT = 3'd2,
    ST_SCAN    = 3'd3,
    ST_OUTPUT  = 3'd4
  } iso16_state_e;

  localparam int ISO16_WARP_WIDTH  = 16;
  localparam int ISO16_ERROR_WIDTH = 32;
  localparam logic [ISO16_ERROR_WIDTH-1:0] ISO16_ERROR_MAX = '1;

  // Bit offset of lane idx inside a packed per-plugin bus.
  function automatic int lane_lsb(input logic [3:0] idx, input int width);
    return int'(idx) * width;
  endfunction

endpackage

// File: rtl/plugin_collector_if.sv
// rtl/plugin_collector_if.sv - plugin bank bus plus result valid/ready port
interface plugin_collector_if #(
  parameter int NUM_PLUGINS = 4,
  parameter int WARP_WIDTH  = 16,
  parameter int ERROR_WIDTH = 32
);
  logic                              plugin_start;
  logic [NUM_PLUGINS-1:0]            plugin_valid;
  logic [NUM_PLUGINS*WARP_WIDTH-1:0] plugin_warp_x;
  logic [NUM_PLUGINS*WARP_WIDTH-1:0] plugin_warp_y;
  logic [NUM_PLUGINS*WARP_WIDTH-1:0] plugin_warp_z;
  logic [NUM_PLUGINS*ERROR_WIDTH-1:0] plugin_error;

  logic                   out_valid;
  logic                   out_ready;
  logic [WARP_WIDTH-1:0]  out_warp_x;
  logic [WARP_WIDTH-1:0]  out_warp_y;
  logic [WARP_WIDTH-1:0]  out_warp_z;
  logic [ERROR_WIDTH-1:0] out_error;
  logic [3:0]             out_idx;
  logic                   out_none;
  logic [NUM_PLUGINS-1:0] out_mask;

  modport master (
    output plugin_start,
    input  plugin_valid, plugin_warp_x, plugin_warp_y, plugin_warp_z, plugin_error,
    output out_valid, out_warp_x, out_warp_y, out_warp_z, out_error, out_idx, out_none, out_mask,
    input  out_ready
  );

  modport slave (
    input  plugin_start,
    output plugin_valid, plugin_warp_x, plugin_warp_y, plugin_warp_z, plugin_error,
    input  out_valid, out_warp_x, out_warp_y, out_warp_z, out_error, out_idx, out_none, out_mask,
    output out_ready
  );
endinterface

// File: rtl/plugin_collector.sv
// rtl/plugin_collector.sv - starts the plugin bank, collects results, picks min-error lane
module plugin_collector
  import iso16_pkg::*;
#(
  parameter int NUM_PLUGINS    = 4,
  parameter int WARP_WIDTH     = ISO16_WARP_WIDTH,
  parameter int ERROR_WIDTH    = ISO16_ERROR_WIDTH,
  parameter int COLLECT_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_start,
  output logic               busy,
  plugin_collector_if.master bus
);

  localparam int CNT_W = (COLLECT_CYCLES > 1) ? $clog2(COLLECT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COLLECT_CYCLES - 1);
  localparam logic [3:0]       IDX_LAST = 4'(NUM_PLUGINS - 1);

  iso16_state_e     state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       scan_idx;
  logic             best_found;

  logic [NUM_PLUGINS-1:0] mask_sh;
  logic [ERROR_WIDTH-1:0] lane_err;
  logic [WARP_WIDTH-1:0]  lane_x, lane_y, lane_z;
  logic                   cand;

  assign busy = (state != ST_IDLE);

  // out_error doubles as the running best error during SCAN.
  always_comb begin
    mask_sh  = bus.out_mask >> scan_idx;
    lane_err = ERROR_WIDTH'(bus.plugin_error >> lane_lsb(scan_idx, ERROR_WIDTH));
    lane_x   = WARP_WIDTH'(bus.plugin_warp_x >> lane_lsb(scan_idx, WARP_WIDTH));
    lane_y   = WARP_WIDTH'(bus.plugin_warp_y >> lane_lsb(scan_idx, WARP_WIDTH));
    lane_z   = WARP_WIDTH'(bus.plugin_warp_z >> lane_lsb(scan_idx, WARP_WIDTH));
    cand     = mask_sh[0] && (!best_found || (lane_err < bus.out_error));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      scan_idx         <= '0;
      best_found       <= 1'b0;
      bus.plugin_start <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.out_warp_x   <= '0;
      bus.out_warp_y   <= '0;
      bus.out_warp_z   <= '0;
      bus.out_error    <= '1;
      bus.out_idx      <= '0;
      bus.out_none     <= 1'b0;
      bus.out_mask     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_start) begin
            state            <= ST_START;
            bus.plugin_start <= 1'b1;
          end
        end
        ST_START: begin
          bus.plugin_start <= 1'b0;
          cnt              <= '0;
          state            <= ST_COLLECT;
        end
        ST_COLLECT: begin
          if ((&bus.plugin_valid) || (cnt == CNT_LAST)) begin
            bus.out_mask   <= bus.plugin_valid;
            best_found     <= 1'b0;
            scan_idx       <= '0;
            bus.out_warp_x <= '0;
            bus.out_warp_y <= '0;
            bus.out_warp_z <= '0;
            bus.out_error  <= '1;
            bus.out_idx    <= '0;
            state          <= ST_SCAN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SCAN: begin
          if (cand) begin
            bus.out_warp_x <= lane_x;
            bus.out_warp_y <= lane_y;
            bus.out_warp_z <= lane_z;
            bus.out_error  <= lane_err;
            bus.out_idx    <= scan_idx;
            best_found     <= 1'b1;
          end
          if (scan_idx == IDX_LAST) begin
            bus.out_none <= !(best_found || cand);
            state        <= ST_OUTPUT;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        ST_OUTPUT: begin
          // out_valid rises one cycle after entering OUTPUT, drops after the transfer.
          if (!bus.out_valid) begin
            bus.out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plugin_collector.sv
// tb/tb_plugin_collector.sv - directed bench for plugin_collector
module tb_plugin_collector;
  import iso16_pkg::*;

  localparam int N  = 4;
  localparam int WW = 16;
  localparam int EW = 32;
  localparam int CC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_start = 1'b0;
  logic busy;
  logic plug_rst = 1'b1;
  logic [N-1:0] lane_en = '0;
  logic [N-1:0] pv = '0;
  int start_cnt = 0;
  int errors = 0;
  int checks = 0;

  plugin_collector_if #(.NUM_PLUGINS(N), .WARP_WIDTH(WW), .ERROR_WIDTH(EW)) bus ();

  plugin_collector #(.NUM_PLUGINS(N), .WARP_WIDTH(WW), .ERROR_WIDTH(EW), .COLLECT_CYCLES(CC)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  // Plugin models: raise valid the cycle after plugin_start, hold until plug_rst.
  always @(posedge clk) begin
    if (plug_rst) pv <= '0;
    else if (bus.plugin_start) pv <= lane_en;
  end
  assign bus.plugin_valid = pv;

  always @(posedge clk) if (bus.plugin_start) start_cnt = start_cnt + 1;

  task automatic set_lanes(input logic [EW-1:0] e0, e1, e2, e3, input logic [N-1:0] en);
    logic [EW-1:0] e [N];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < N; i++) begin
      bus.plugin_error[i*EW +: EW] = e[i];
      bus.plugin_warp_x[i*WW +: WW] = 16'h1100 + 16'(i);
      bus.plugin_warp_y[i*WW +: WW] = 16'h2200 + 16'(i);
      bus.plugin_warp_z[i*WW +: WW] = 16'h3300 + 16'(i);
    end
    lane_en = en;
    @(negedge clk); plug_rst = 1'b1;
    @(negedge clk); plug_rst = 1'b0;
  endtask

  // Ends at the negedge after the edge that sampled cmd_start.
  task automatic kick;
    @(negedge clk); cmd_start = 1'b1;
    @(negedge clk); cmd_start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin lat = k; return; end
    end
  endtask

  task automatic drain;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy === 1'b0 && bus.out_valid === 1'b0) return;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bus.plugin_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", bus.plugin_start); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_error !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_error: got %h want ffffffff", bus.out_error); end
    checks++; if ({bus.out_warp_x, bus.out_warp_y, bus.out_warp_z, bus.out_idx, bus.out_none, bus.out_mask} !== '0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {bus.out_warp_x, bus.out_warp_y, bus.out_warp_z, bus.out_idx, bus.out_none, bus.out_mask});
    end
    rst = 1'b0;
  endtask

  task automatic test_min_error;
    int lat;
    set_lanes(5, 3, 3, 9, 4'b1111);
    kick();
    wait_valid(lat);
    checks++; if (lat !== 7) begin errors++; $display("FAIL min_latency: got %0d want 7", lat); end
    checks++; if (bus.out_idx !== 4'd1) begin errors++; $display("FAIL min_idx: got %0d want 1", bus.out_idx); end
    checks++; if (bus.out_error !== 32'd3) begin errors++; $display("FAIL min_error: got %0d want 3", bus.out_error); end
    checks++; if (bus.out_mask !== 4'b1111) begin errors++; $display("FAIL min_mask: got %b want 1111", bus.out_mask); end
    checks++; if ({bus.out_warp_x, bus.out_warp_y, bus.out_warp_z} !== {16'h1101, 16'h2201, 16'h3301}) begin
      errors++; $display("FAIL min_warp: got %h %h %h want 1101 2201 3301", bus.out_warp_x, bus.out_warp_y, bus.out_warp_z);
    end
    checks++; if (bus.out_none !== 1'b0) begin errors++; $display("FAIL min_none: got %b want 0", bus.out_none); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL min_after_xfer: got valid=%b busy=%b want 0 0", bus.out_valid, busy);
    end
  endtask

  task automatic test_timeout;
    int lat;
    set_lanes(7, 6, 1, 6, 4'b1011);
    kick();
    wait_valid(lat);
    checks++; if (lat !== CC + N + 2) begin errors++; $display("FAIL to_latency: got %0d want %0d", lat, CC + N + 2); end
    checks++; if (bus.out_mask !== 4'b1011) begin errors++; $display("FAIL to_mask: got %b want 1011", bus.out_mask); end
    checks++; if (bus.out_idx !== 4'd1) begin errors++; $display("FAIL to_idx: got %0d want 1", bus.out_idx); end
    checks++; if (bus.out_error !== 32'd6) begin errors++; $display("FAIL to_error: got %0d want 6", bus.out_error); end
    drain();
  endtask

  task automatic test_none;
    int lat;
    set_lanes(2, 2, 2, 2, 4'b0000);
    kick();
    wait_valid(lat);
    checks++; if (lat !== 14) begin errors++; $display("FAIL none_latency: got %0d want 14", lat); end
    checks++; if (bus.out_none !== 1'b1) begin errors++; $display("FAIL none_flag: got %b want 1", bus.out_none); end
    checks++; if (bus.out_error !== 32'hFFFFFFFF) begin errors++; $display("FAIL none_error: got %h want ffffffff", bus.out_error); end
    checks++; if ({bus.out_warp_x, bus.out_warp_y, bus.out_warp_z, bus.out_idx, bus.out_mask} !== '0) begin
      errors++; $display("FAIL none_data: got %h %h %h idx %0d mask %b want all 0", bus.out_warp_x, bus.out_warp_y, bus.out_warp_z, bus.out_idx, bus.out_mask);
    end
    drain();
  endtask

  task automatic test_backpressure;
    int lat;
    int starts0;
    int unstable;
    logic [WW*3+EW+4-1:0] snap;
    set_lanes(4, 8, 2, 6, 4'b1111);
    bus.out_ready = 1'b0;
    starts0 = start_cnt;
    kick();
    wait_valid(lat);
    checks++; if (lat !== 7) begin errors++; $display("FAIL bp_latency: got %0d want 7", lat); end
    snap = {bus.out_warp_x, bus.out_warp_y, bus.out_warp_z, bus.out_error, bus.out_idx};
    unstable = 0;
    for (int k = 0; k < 5; k++) begin
      cmd_start = (k == 1 || k == 2);
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || {bus.out_warp_x, bus.out_warp_y, bus.out_warp_z, bus.out_error, bus.out_idx} !== snap) unstable++;
    end
    cmd_start = 1'b0;
    checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", unstable); end
    checks++; if (snap !== {16'h1102, 16'h2202, 16'h3302, 32'd2, 4'd2}) begin errors++; $display("FAIL bp_result: got %h want idx 2 error 2", snap); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_single_xfer: got valid=%b want 0", bus.out_valid); end
    repeat (4) @(negedge clk);
    checks++; if (start_cnt - starts0 !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_cmd_ignored: got starts=%0d busy=%b want 1 0", start_cnt - starts0, busy);
    end
  endtask

  task automatic test_reset_mid_scan;
    int lat;
    set_lanes(9, 1, 5, 7, 4'b1111);
    kick();
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1 || bus.out_idx !== 4'd1) begin
      errors++; $display("FAIL rs_pre: got busy=%b idx=%0d want 1 1", busy, bus.out_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || bus.plugin_start !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rs_ctrl: got busy=%b start=%b valid=%b want 0 0 0", busy, bus.plugin_start, bus.out_valid);
    end
    checks++; if (bus.out_error !== 32'hFFFFFFFF || bus.out_idx !== 4'd0 || bus.out_mask !== 4'b0000) begin
      errors++; $display("FAIL rs_data: got err=%h idx=%0d mask=%b want ffffffff 0 0000", bus.out_error, bus.out_idx, bus.out_mask);
    end
    set_lanes(9, 1, 5, 7, 4'b1111);
    kick();
    wait_valid(lat);
    checks++; if (lat !== 7 || bus.out_idx !== 4'd1 || bus.out_error !== 32'd1) begin
      errors++; $display("FAIL rs_rerun: got lat=%0d idx=%0d err=%0d want 7 1 1", lat, bus.out_idx, bus.out_error);
    end
    drain();
  endtask

  task automatic test_tie;
    int lat;
    set_lanes(1, 1, 1, 1, 4'b1111);
    for (int i = 0; i < N; i++) begin
      bus.plugin_warp_x[i*WW +: WW] = 16'(i);
      bus.plugin_warp_y[i*WW +: WW] = 16'(i);
      bus.plugin_warp_z[i*WW +: WW] = 16'(i);
    end
    kick();
    wait_valid(lat);
    checks++; if (bus.out_idx !== 4'd0 || bus.out_error !== 32'd1) begin
      errors++; $display("FAIL tie_idx: got idx=%0d err=%0d want 0 1", bus.out_idx, bus.out_error);
    end
    checks++; if ({bus.out_warp_x, bus.out_warp_y, bus.out_warp_z} !== 48'd0) begin
      errors++; $display("FAIL tie_warp: got %h %h %h want 0 0 0", bus.out_warp_x, bus.out_warp_y, bus.out_warp_z);
    end
    drain();
  endtask

  initial begin
    bus.out_ready = 1'b1;
    bus.plugin_error = '0;
    bus.plugin_warp_x = '0;
    bus.plugin_warp_y = '0;
    bus.plugin_warp_z = '0;
    test_reset();
    test_min_error();
    test_timeout();
    test_none();
    test_backpressure();
    test_reset_mid_scan();
    test_tie();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
